scratchpad_banked: RTL and testbench

SCRATCHPAD_BANKED -- requirements
Module: scratchpad_banked

---
 rtl/scratchpad_pkg.sv | 51 +++++
 rtl/scratchpad_banked_if.sv | 25 ++
 rtl/scratchpad_bank.sv | 32 +++
 rtl/scratchpad_banked.sv | 161 ++++++++++++++++
 tb/tb_scratchpad_banked.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/scratchpad_pkg.sv
// Shared types and helpers for the banked scratchpad: access size codes,
// their byte counts, lane enables, data masks and the default base address.
package scratchpad_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_WORD   = 2'b10,
        SZ_DOUBLE = 2'b11
    } size_e;

    localparam logic [63:0] DEFAULT_BASE = 64'h0300_0000_0000_0000;

    function automatic logic [3:0] sizeBytes(input size_e sz);
        case (sz)
            SZ_BYTE: return 4'd1;
            SZ_HALF: return 4'd2;
            SZ_WORD: return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Low offset bits that must be zero for a naturally aligned access
    function automatic logic [2:0] alignMask(input size_e sz);
        case (sz)
            SZ_BYTE: return 3'b000;
            SZ_HALF: return 3'b001;
            SZ_WORD: return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] byteEnables(input size_e sz);
        case (sz)
            SZ_BYTE: return 8'h01;
            SZ_HALF: return 8'h03;
            SZ_WORD: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] dataMask(input size_e sz);
        case (sz)
            SZ_BYTE: return 64'h0000_0000_0000_00FF;
            SZ_HALF: return 64'h0000_0000_0000_FFFF;
            SZ_WORD: return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/scratchpad_banked_if.sv
// Request/response bundle between requesters and the banked scratchpad;
// every field is a packed vector with one slice per port.
interface scratchpad_banked_if #(
    parameter int unsigned NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]    req_valid;
    logic [NUM_PORTS-1:0]    req_ready;
    logic [NUM_PORTS-1:0]    req_write;
    logic [2*NUM_PORTS-1:0]  req_len;
    logic [64*NUM_PORTS-1:0] req_addr;
    logic [64*NUM_PORTS-1:0] req_wdata;
    logic [NUM_PORTS-1:0]    resp_valid;
    logic [NUM_PORTS-1:0]    resp_err;
    logic [64*NUM_PORTS-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_len, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_len, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/scratchpad_bank.sv
// One scratchpad bank: 64-bit rows, byte-granular writes, registered read
// data available the cycle after the access. Contents are never reset.
module scratchpad_bank #(
    parameter int unsigned ROWS  = 16384,
    parameter int unsigned ROW_W = 14
)(
    input  logic             clk,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [ROW_W-1:0] i_row,
    input  logic [7:0]       i_be,
    input  logic [63:0]      i_wdata,
    output logic [63:0]      o_rdata
);
    logic [63:0] r_mem [ROWS];
    logic [63:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < 8; i++) begin
                    if (i_be[i]) begin
                        r_mem[i_row][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end
            r_rdata <= r_mem[i_row];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/scratchpad_banked.sv
// Multi-port banked scratchpad: per-port range/alignment check, per-bank
// round-robin arbitration, and a one-cycle response pipeline.
module scratchpad_banked
    import scratchpad_pkg::*;
#(
    parameter int unsigned CHUNK_SIZE      = 512,
    parameter int unsigned NUM_CHUNKS      = 1024,
    parameter logic [63:0] SCRATCHPAD_BASE = DEFAULT_BASE,
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned NUM_BANKS       = 4
)(
    input logic                clk,
    input logic                rst,
    scratchpad_banked_if.slave bus
);
    localparam logic [63:0] SIZE64    = 64'(CHUNK_SIZE) * 64'(NUM_CHUNKS);
    localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
    localparam int unsigned BANK_W    = (NUM_BANKS > 1) ? BANK_BITS : 1;
    localparam int unsigned ROWS      = int'(SIZE64 / 64'(8 * NUM_BANKS));
    localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    function automatic int rrIndex(input int ptr, input int k);
        return (ptr + k) % int'(NUM_PORTS);
    endfunction

    logic [63:0]          w_offset [NUM_PORTS];
    size_e                w_size   [NUM_PORTS];
    logic [BANK_W-1:0]    w_bank   [NUM_PORTS];
    logic [ROW_W-1:0]     w_row    [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_bad;
    logic [NUM_PORTS-1:0] w_grant;
    logic [NUM_PORTS-1:0] w_ready;

    logic [NUM_BANKS-1:0] w_bankEn;
    logic [NUM_BANKS-1:0] w_bankWe;
    logic [ROW_W-1:0]     w_bankRow   [NUM_BANKS];
    logic [7:0]           w_bankBe    [NUM_BANKS];
    logic [63:0]          w_bankWdata [NUM_BANKS];
    logic [63:0]          w_bankRdata [NUM_BANKS];
    logic [PORT_W-1:0]    w_ptrNext   [NUM_BANKS];
    logic [PORT_W-1:0]    r_rrPtr     [NUM_BANKS];

    logic [NUM_PORTS-1:0]    r_respValid;
    logic [NUM_PORTS-1:0]    r_respErr;
    logic [NUM_PORTS-1:0]    r_respLoad;
    logic [BANK_W-1:0]       r_respBank [NUM_PORTS];
    logic [2:0]              r_respLane [NUM_PORTS];
    size_e                   r_respSize [NUM_PORTS];
    logic [64*NUM_PORTS-1:0] w_respRdata;

    // Out-of-range or misaligned requests never touch a bank
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_offset[p] = bus.req_addr[64*p +: 64] - SCRATCHPAD_BASE;
            w_size[p]   = size_e'(bus.req_len[2*p +: 2]);
            w_bad[p]    = (bus.req_addr[64*p +: 64] < SCRATCHPAD_BASE)
                       || (w_offset[p] > (SIZE64 - 64'(sizeBytes(w_size[p]))))
                       || ((w_offset[p][2:0] & alignMask(w_size[p])) != 3'b000);
            w_bank[p]   = BANK_W'((w_offset[p] >> 3) & 64'(NUM_BANKS - 1));
            w_row[p]    = ROW_W'(w_offset[p] >> (3 + BANK_BITS));
        end
    end

    always_comb begin
        w_grant = '0;
        w_bankEn = '0;
        w_bankWe = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_bankRow[b]   = '0;
            w_bankBe[b]    = '0;
            w_bankWdata[b] = '0;
            w_ptrNext[b]   = r_rrPtr[b];
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!rst && !w_bankEn[b]
                    && bus.req_valid[rrIndex(int'(r_rrPtr[b]), k)]
                    && !w_bad[rrIndex(int'(r_rrPtr[b]), k)]
                    && (int'(w_bank[rrIndex(int'(r_rrPtr[b]), k)]) == b)) begin
                    w_bankEn[b] = 1'b1;
                    w_grant[rrIndex(int'(r_rrPtr[b]), k)] = 1'b1;
                    w_bankWe[b]    = bus.req_write[rrIndex(int'(r_rrPtr[b]), k)];
                    w_bankRow[b]   = w_row[rrIndex(int'(r_rrPtr[b]), k)];
                    w_bankBe[b]    = byteEnables(w_size[rrIndex(int'(r_rrPtr[b]), k)])
                                     << w_offset[rrIndex(int'(r_rrPtr[b]), k)][2:0];
                    w_bankWdata[b] = bus.req_wdata[64*rrIndex(int'(r_rrPtr[b]), k) +: 64]
                                     << {w_offset[rrIndex(int'(r_rrPtr[b]), k)][2:0], 3'b000};
                    w_ptrNext[b]   = PORT_W'(rrIndex(int'(r_rrPtr[b]), k + 1));
                end
            end
        end
    end

    assign w_ready       = rst ? '0 : (bus.req_valid & (w_bad | w_grant));
    assign bus.req_ready = w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_rrPtr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_rrPtr[b] <= w_ptrNext[b];
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        scratchpad_bank #(
            .ROWS  (ROWS),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk     (clk),
            .i_en    (w_bankEn[b]),
            .i_we    (w_bankWe[b]),
            .i_row   (w_bankRow[b]),
            .i_be    (w_bankBe[b]),
            .i_wdata (w_bankWdata[b]),
            .o_rdata (w_bankRdata[b])
        );
    end

    // Remember where each accepted load lands so the next cycle can pick its bytes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_respValid <= '0;
            r_respErr   <= '0;
            r_respLoad  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_respBank[p] <= '0;
                r_respLane[p] <= '0;
                r_respSize[p] <= SZ_BYTE;
            end
        end else begin
            r_respValid <= w_ready;
            r_respErr   <= w_ready & w_bad;
            r_respLoad  <= w_ready & ~bus.req_write;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_ready[p]) begin
                    r_respBank[p] <= w_bank[p];
                    r_respLane[p] <= w_offset[p][2:0];
                    r_respSize[p] <= w_size[p];
                end
            end
        end
    end

    always_comb begin
        w_respRdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_respValid[p] && r_respLoad[p] && !r_respErr[p]) begin
                w_respRdata[64*p +: 64] = (w_bankRdata[r_respBank[p]] >> {r_respLane[p], 3'b000})
                                          & dataMask(r_respSize[p]);
            end
        end
    end

    assign bus.resp_valid = r_respValid;
    assign bus.resp_err   = r_respErr;
    assign bus.resp_rdata = w_respRdata;
endmodule

// File: tb/tb_scratchpad_banked.sv
// Directed bench for scratchpad_banked at default parameters: loads/stores,
// error cases, bank contention, parallel banks and reset mid-flight.
module tb_scratchpad_banked;
    import scratchpad_pkg::*;

    localparam logic [63:0] BASE = 64'h0300_0000_0000_0000;
    localparam logic [63:0] SIZE = 64'd524288;

    logic clk;
    logic rst;
    int   nVec;
    int   nFail;

    scratchpad_banked_if #(.NUM_PORTS(2)) bus ();

    scratchpad_banked #(
        .CHUNK_SIZE      (512),
        .NUM_CHUNKS      (1024),
        .SCRATCHPAD_BASE (BASE),
        .NUM_PORTS       (2),
        .NUM_BANKS       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request on port p starting just after a rising edge; return
    // the ready seen that cycle and the response seen after the next edge.
    task automatic doReq(input int p, input logic wr, input logic [1:0] len,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         output logic rdy, output logic rv, output logic re,
                         output logic [63:0] rd);
        bus.req_valid[p]             = 1'b1;
        bus.req_write[p]             = wr;
        bus.req_len[2*p +: 2]        = len;
        bus.req_addr[64*p +: 64]     = addr;
        bus.req_wdata[64*p +: 64]    = wdata;
        #1;
        rdy = bus.req_ready[p];
        @(posedge clk);
        #1;
        bus.req_valid[p] = 1'b0;
        rv = bus.resp_valid[p];
        re = bus.resp_err[p];
        rd = bus.resp_rdata[64*p +: 64];
    endtask

    task automatic test_reset();
        bus.req_valid = 2'b11;
        bus.req_addr  = '0;
        #1;
        nVec++; if (bus.req_ready !== 2'b00) begin nFail++; $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
        nVec++; if (bus.resp_valid !== 2'b00) begin nFail++; $display("FAIL reset_resp_valid: got %b want 00", bus.resp_valid); end
        nVec++; if (bus.resp_err !== 2'b00) begin nFail++; $display("FAIL reset_resp_err: got %b want 00", bus.resp_err); end
        nVec++; if (bus.resp_rdata !== 128'h0) begin nFail++; $display("FAIL reset_resp_rdata: got %h want 0", bus.resp_rdata); end
        bus.req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        logic rdy, rv, re;
        logic [63:0] rd;
        doReq(0, 1'b1, 2'b11, BASE + 64'h10, 64'h1122334455667788, rdy, rv, re, rd);
        nVec++; if (rdy !== 1'b1) begin nFail++; $display("FAIL st_dbl_ready: got %b want 1", rdy); end
        nVec++; if ({rv, re} !== 2'b10 || rd !== 64'h0) begin nFail++; $display("FAIL st_dbl_resp: got v%b e%b %h want v1 e0 0", rv, re, rd); end
        doReq(0, 1'b0, 2'b11, BASE + 64'h10, 64'h0, rdy, rv, re, rd);
        nVec++; if ({rdy, rv, re} !== 3'b110) begin nFail++; $display("FAIL ld_dbl_flags: got r%b v%b e%b want r1 v1 e0", rdy, rv, re); end
        nVec++; if (rd !== 64'h1122334455667788) begin nFail++; $display("FAIL ld_dbl_data: got %h want 1122334455667788", rd); end
        doReq(0, 1'b0, 2'b00, BASE + 64'h13, 64'h0, rdy, rv, re, rd);
        nVec++; if ({rv, re} !== 2'b10 || rd !== 64'h55) begin nFail++; $display("FAIL ld_byte: got v%b e%b %h want v1 e0 55", rv, re, rd); end
        doReq(0, 1'b1, 2'b01, BASE + 64'h12, 64'h0000_0000_0000_BEEF, rdy, rv, re, rd);
        nVec++; if ({rdy, rv, re} !== 3'b110) begin nFail++; $display("FAIL st_half: got r%b v%b e%b want r1 v1 e0", rdy, rv, re); end
        doReq(0, 1'b0, 2'b11, BASE + 64'h10, 64'h0, rdy, rv, re, rd);
        nVec++; if (rd !== 64'h11223344BEEF7788) begin nFail++; $display("FAIL ld_after_half: got %h want 11223344beef7788", rd); end
    endtask

    task automatic test_back_to_back();
        logic rdy, rv, re;
        logic [63:0] rd;
        doReq(0, 1'b1, 2'b10, BASE + 64'h40, 64'hFFFF_FFFF_CAFE_BABE, rdy, rv, re, rd);
        doReq(0, 1'b0, 2'b10, BASE + 64'h40, 64'h0, rdy, rv, re, rd);
        nVec++; if ({rv, re} !== 2'b10 || rd !== 64'hCAFEBABE) begin nFail++; $display("FAIL raw_word: got v%b e%b %h want v1 e0 cafebabe", rv, re, rd); end
        doReq(0, 1'b0, 2'b01, BASE + 64'h42, 64'h0, rdy, rv, re, rd);
        nVec++; if (rd !== 64'hCAFE) begin nFail++; $display("FAIL ld_half_hi: got %h want cafe", rd); end
        doReq(1, 1'b0, 2'b00, BASE + 64'h43, 64'h0, rdy, rv, re, rd);
        nVec++; if ({rv, re} !== 2'b10 || rd !== 64'hCA) begin nFail++; $display("FAIL p1_ld_byte: got v%b e%b %h want v1 e0 ca", rv, re, rd); end
    endtask

    task automatic test_errors();
        logic rdy, rv, re;
        logic [63:0] rd;
        doReq(0, 1'b0, 2'b11, BASE + SIZE, 64'h0, rdy, rv, re, rd);
        nVec++; if ({rdy, rv, re} !== 3'b111 || rd !== 64'h0) begin nFail++; $display("FAIL err_past_end: got r%b v%b e%b %h want r1 v1 e1 0", rdy, rv, re, rd); end
        doReq(0, 1'b0, 2'b11, BASE - 64'h8, 64'h0, rdy, rv, re, rd);
        nVec++; if ({rdy, rv, re} !== 3'b111 || rd !== 64'h0) begin nFail++; $display("FAIL err_below_base: got r%b v%b e%b %h want r1 v1 e1 0", rdy, rv, re, rd); end
        doReq(0, 1'b0, 2'b01, BASE + 64'h1, 64'h0, rdy, rv, re, rd);
        nVec++; if ({rdy, rv, re} !== 3'b111 || rd !== 64'h0) begin nFail++; $display("FAIL err_misalign: got r%b v%b e%b %h want r1 v1 e1 0", rdy, rv, re, rd); end
        doReq(1, 1'b1, 2'b10, BASE + 64'h12, 64'h0000_0000_FFFF_FFFF, rdy, rv, re, rd);
        nVec++; if ({rdy, rv, re} !== 3'b111) begin nFail++; $display("FAIL err_st_misalign: got r%b v%b e%b want r1 v1 e1", rdy, rv, re); end
        doReq(0, 1'b0, 2'b11, BASE + 64'h10, 64'h0, rdy, rv, re, rd);
        nVec++; if (rd !== 64'h11223344BEEF7788) begin nFail++; $display("FAIL err_no_write: got %h want 11223344beef7788", rd); end
        doReq(0, 1'b1, 2'b11, BASE + SIZE - 64'h8, 64'hDEAD_BEEF_00C0_FFEE, rdy, rv, re, rd);
        doReq(0, 1'b0, 2'b11, BASE + SIZE - 64'h8, 64'h0, rdy, rv, re, rd);
        nVec++; if ({rv, re} !== 2'b10 || rd !== 64'hDEADBEEF00C0FFEE) begin nFail++; $display("FAIL last_dbl: got v%b e%b %h want v1 e0 deadbeef00c0ffee", rv, re, rd); end
    endtask

    task automatic test_contention();
        logic rdy, rv, re;
        logic [63:0] rd;
        logic [1:0] expReady [4];
        logic [1:0] expResp;
        expReady[0] = 2'b01; expReady[1] = 2'b10; expReady[2] = 2'b01; expReady[3] = 2'b10;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        doReq(0, 1'b1, 2'b11, BASE, 64'hA5A5_0000_0000_0001, rdy, rv, re, rd);
        doReq(1, 1'b1, 2'b11, BASE + 64'h20, 64'h5A5A_0000_0000_0002, rdy, rv, re, rd);
        @(posedge clk);
        #1;
        bus.req_write = 2'b00;
        bus.req_len   = 4'b1111;
        bus.req_addr  = {BASE + 64'h20, BASE};
        bus.req_valid = 2'b11;
        expResp = 2'b00;
        for (int i = 0; i < 4; i++) begin
            #1;
            nVec++; if (bus.req_ready !== expReady[i]) begin nFail++; $display("FAIL rr_grant%0d: got %b want %b", i, bus.req_ready, expReady[i]); end
            nVec++; if (bus.resp_valid !== expResp) begin nFail++; $display("FAIL rr_resp%0d: got %b want %b", i, bus.resp_valid, expResp); end
            if (expResp == 2'b01) begin
                nVec++; if (bus.resp_rdata[63:0] !== 64'hA5A5_0000_0000_0001) begin nFail++; $display("FAIL rr_data%0d: got %h want a5a5000000000001", i, bus.resp_rdata[63:0]); end
            end else if (expResp == 2'b10) begin
                nVec++; if (bus.resp_rdata[127:64] !== 64'h5A5A_0000_0000_0002) begin nFail++; $display("FAIL rr_data%0d: got %h want 5a5a000000000002", i, bus.resp_rdata[127:64]); end
            end
            expResp = expReady[i];
            @(posedge clk);
            #1;
        end
        bus.req_valid = 2'b00;
        #1;
        nVec++; if (bus.resp_valid !== 2'b10) begin nFail++; $display("FAIL rr_resp_last: got %b want 10", bus.resp_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_parallel_banks();
        bus.req_write = 2'b11;
        bus.req_len   = 4'b1111;
        bus.req_addr  = {BASE + 64'h8, BASE};
        bus.req_wdata = {64'hA0A1_A2A3_A4A5_A6A7, 64'h0102_0304_0506_0708};
        bus.req_valid = 2'b11;
        #1;
        nVec++; if (bus.req_ready !== 2'b11) begin nFail++; $display("FAIL par_st_ready: got %b want 11", bus.req_ready); end
        @(posedge clk);
        #1;
        nVec++; if (bus.resp_valid !== 2'b11 || bus.resp_err !== 2'b00) begin nFail++; $display("FAIL par_st_resp: got v%b e%b want v11 e00", bus.resp_valid, bus.resp_err); end
        bus.req_write = 2'b00;
        #1;
        nVec++; if (bus.req_ready !== 2'b11) begin nFail++; $display("FAIL par_ld_ready: got %b want 11", bus.req_ready); end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        nVec++; if (bus.resp_valid !== 2'b11) begin nFail++; $display("FAIL par_ld_resp: got %b want 11", bus.resp_valid); end
        nVec++; if (bus.resp_rdata !== {64'hA0A1_A2A3_A4A5_A6A7, 64'h0102_0304_0506_0708}) begin nFail++; $display("FAIL par_ld_data: got %h want a0a1a2a3a4a5a6a70102030405060708", bus.resp_rdata); end
    endtask

    task automatic test_reset_inflight();
        logic rdy, rv, re;
        logic [63:0] rd;
        bus.req_write[0]   = 1'b0;
        bus.req_len[1:0]   = 2'b11;
        bus.req_addr[63:0] = BASE + 64'h10;
        bus.req_valid      = 2'b01;
        #1;
        nVec++; if (bus.req_ready !== 2'b01) begin nFail++; $display("FAIL inflight_ready: got %b want 01", bus.req_ready); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        nVec++; if (bus.resp_valid !== 2'b00 || bus.resp_err !== 2'b00 || bus.resp_rdata !== 128'h0) begin nFail++; $display("FAIL inflight_drop: got v%b e%b %h want all 0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        nVec++; if (bus.req_ready !== 2'b00) begin nFail++; $display("FAIL inflight_rst_ready: got %b want 00", bus.req_ready); end
        bus.req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        nVec++; if (bus.resp_valid !== 2'b00) begin nFail++; $display("FAIL inflight_no_resp: got %b want 00", bus.resp_valid); end
        doReq(0, 1'b0, 2'b11, BASE + 64'h10, 64'h0, rdy, rv, re, rd);
        nVec++; if ({rdy, rv, re} !== 3'b110 || rd !== 64'h11223344BEEF7788) begin nFail++; $display("FAIL after_rst_ld: got r%b v%b e%b %h want r1 v1 e0 11223344beef7788", rdy, rv, re, rd); end
    endtask

    initial begin
        nVec          = 0;
        nFail         = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_len   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_errors();
        test_contention();
        test_parallel_banks();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
